// File: rtl/assay_readout_scanner_if.sv
// Host-side bundle for the assay readout scanner: run control, detector samples
// and the valid/ready result stream.
interface assay_readout_scanner_if #(
   parameter int unsigned DW = 12
);
   logic            start;
   logic            busy;
   logic            det_strobe;
   logic [8*DW-1:0] det_data;
   logic            res_valid;
   logic            res_ready;
   logic [2:0]      res_ch;
   logic [DW-1:0]   res_avg;
   logic            res_pos;
   logic            res_last;
   logic            done;
   logic            overrun;

   modport master (
      output start, det_strobe, det_data, res_ready,
      input  busy, res_valid, res_ch, res_avg, res_pos, res_last, done, overrun
   );

   modport slave (
      input  start, det_strobe, det_data, res_ready,
      output busy, res_valid, res_ch, res_avg, res_pos, res_last, done, overrun
   );
endinterface

// File: rtl/assay_readout_scanner.sv
// Averages NSAMP samples on each of the eight optical lanes, then streams one
// thresholded result per lane over valid/ready, ending the run with a done pulse.
module assay_readout_scanner #(
   parameter int unsigned DW     = 12,
   parameter int unsigned NSAMP  = 16,
   parameter int unsigned THRESH = 2048
) (
   input  logic                   clk,
   input  logic                   rst_n,
   assay_readout_scanner_if.slave bus
);
   localparam int unsigned LG = $clog2(NSAMP);
   localparam int unsigned AW = DW + LG;
   localparam logic [LG-1:0] CNT_LAST = LG'(NSAMP - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] acc_q [8];
   logic [AW-1:0] acc_d [8];
   logic [LG-1:0] cnt_q, cnt_d;
   logic [2:0]    ptr_q, ptr_d;
   logic          busy_q, busy_d;
   logic          res_valid_q, res_valid_d;
   logic          done_q, done_d;
   logic          overrun_q, overrun_d;
   logic          hs;
   logic [DW-1:0] avg;

   assign hs = res_valid_q & bus.res_ready;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      busy_d      = busy_q;
      res_valid_d = res_valid_q;
      done_d      = 1'b0;
      overrun_d   = overrun_q;
      case (state_q)
         IDLE: begin
            // A strobe coinciding with start is dropped: accumulation begins next cycle.
            if (bus.start) begin
               for (int unsigned i = 0; i < 8; i++) acc_d[i] = '0;
               cnt_d     = '0;
               ptr_d     = '0;
               overrun_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.det_strobe) begin
               for (int unsigned i = 0; i < 8; i++)
                  acc_d[i] = acc_q[i] + AW'(bus.det_data[i*DW +: DW]);
               cnt_d = cnt_q + LG'(1);
               if (cnt_q == CNT_LAST) begin
                  ptr_d       = '0;
                  res_valid_d = 1'b1;
                  state_d     = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (bus.det_strobe) overrun_d = 1'b1;
            if (hs) begin
               if (ptr_q == 3'd7) begin
                  ptr_d       = '0;
                  res_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  state_d     = IDLE;
               end else begin
                  ptr_d = ptr_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         for (int unsigned i = 0; i < 8; i++) acc_q[i] <= '0;
         cnt_q       <= '0;
         ptr_q       <= '0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
      end
   end

   // Payload is taken straight from registers, so it cannot move while stalled.
   assign avg           = acc_q[ptr_q][AW-1:LG];
   assign bus.busy      = busy_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_ch    = ptr_q;
   assign bus.res_avg   = avg;
   assign bus.res_pos   = (32'(avg) >= THRESH);
   assign bus.res_last  = res_valid_q & (ptr_q == 3'd7);
   assign bus.done      = done_q;
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_assay_readout_scanner.sv
// Directed bench for assay_readout_scanner: table of lane patterns with
// hand-computed averages, plus stall, overrun and mid-run reset sequences.
module tb_assay_readout_scanner;
   localparam int unsigned DW     = 12;
   localparam int unsigned NSAMP  = 16;
   localparam int unsigned THRESH = 400;

   typedef struct {
      logic [7:0][DW-1:0] ev;   // lane values on even strobes
      logic [7:0][DW-1:0] od;   // lane values on odd strobes
      logic [7:0][DW-1:0] avg;  // expected averages
      logic [7:0]         pos;  // expected positive flags
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [3];

   assay_readout_scanner_if #(.DW(DW)) bus ();

   assay_readout_scanner #(
      .DW(DW),
      .NSAMP(NSAMP),
      .THRESH(THRESH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_valid"}, 32'(bus.res_valid), 0);
      check({tag, "_done"}, 32'(bus.done), 0);
      check({tag, "_overrun"}, 32'(bus.overrun), 0);
      check({tag, "_ch"}, 32'(bus.res_ch), 0);
      check({tag, "_avg"}, 32'(bus.res_avg), 0);
      check({tag, "_pos"}, 32'(bus.res_pos), 0);
      check({tag, "_last"}, 32'(bus.res_last), 0);
   endtask

   // Start a run, then apply NSAMP strobes; returns at the cycle after the last strobe.
   task automatic accum_run(input int unsigned vi, input bit strobe_with_start, input bit mid_start);
      bus.start      = 1'b1;
      bus.det_strobe = strobe_with_start;
      bus.det_data   = '1;
      tick();
      bus.start      = 1'b0;
      bus.det_strobe = 1'b0;
      check("busy_after_start", 32'(bus.busy), 1);
      check("overrun_cleared_by_start", 32'(bus.overrun), 0);
      check("done_low_in_accum", 32'(bus.done), 0);
      for (int n = 0; n < int'(NSAMP); n++) begin
         bus.det_strobe = 1'b1;
         bus.det_data   = (n % 2 == 0) ? vecs[vi].ev : vecs[vi].od;
         bus.start      = mid_start && (n == 5 || n == 10);
         tick();
         if (n == int'(NSAMP) - 2) check("valid_low_before_last_strobe", 32'(bus.res_valid), 0);
      end
      bus.det_strobe = 1'b0;
      bus.start      = 1'b0;
   endtask

   // Drain all eight results with res_ready high; returns at the done cycle.
   task automatic drain_full(input int unsigned vi, input bit strobe_last, input bit exp_ovr);
      bus.res_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check("drain_valid", 32'(bus.res_valid), 1);
         check("drain_busy", 32'(bus.busy), 1);
         check("drain_ch", 32'(bus.res_ch), 32'(k));
         check("drain_avg", 32'(bus.res_avg), 32'(vecs[vi].avg[k]));
         check("drain_pos", 32'(bus.res_pos), 32'(vecs[vi].pos[k]));
         check("drain_last", 32'(bus.res_last), (k == 7) ? 1 : 0);
         bus.det_strobe = strobe_last && (k == 7);
         tick();
      end
      bus.det_strobe = 1'b0;
      bus.res_ready  = 1'b0;
      check("after_drain_valid", 32'(bus.res_valid), 0);
      check("after_drain_busy", 32'(bus.busy), 0);
      check("after_drain_done", 32'(bus.done), 1);
      check("after_drain_overrun", 32'(bus.overrun), 32'(exp_ovr));
   endtask

   initial begin
      int  nxt;
      bit  seen_done;

      vecs[0].ev  = {12'd800, 12'd700, 12'd600, 12'd500, 12'd400, 12'd300, 12'd200, 12'd100};
      vecs[0].od  = vecs[0].ev;
      vecs[0].avg = {12'd800, 12'd700, 12'd600, 12'd500, 12'd400, 12'd300, 12'd200, 12'd100};
      vecs[0].pos = 8'b1111_1000;
      vecs[1].ev  = {8{12'd4095}};
      vecs[1].od  = {8{12'd4095}};
      vecs[1].avg = {8{12'd4095}};
      vecs[1].pos = 8'b1111_1111;
      vecs[2].ev  = {12'd1000, 12'd10, 12'd4095, 12'd0,  12'd400, 12'd399, 12'd0, 12'd1};
      vecs[2].od  = {12'd1000, 12'd11, 12'd0,    12'd15, 12'd401, 12'd400, 12'd0, 12'd2};
      vecs[2].avg = {12'd1000, 12'd10, 12'd2047, 12'd7,  12'd400, 12'd399, 12'd0, 12'd1};
      vecs[2].pos = 8'b1010_1000;

      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.det_strobe = 1'b0;
      bus.det_data   = '0;
      bus.res_ready  = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Strobes in IDLE are ignored and raise no flag.
      bus.det_strobe = 1'b1;
      bus.det_data   = '1;
      repeat (3) tick();
      bus.det_strobe = 1'b0;
      check("idle_strobe_busy", 32'(bus.busy), 0);
      check("idle_strobe_overrun", 32'(bus.overrun), 0);
      check("idle_strobe_valid", 32'(bus.res_valid), 0);

      // Table runs, back-to-back: each start lands on the previous done cycle.
      for (int vi = 0; vi < 3; vi++) begin
         accum_run(vi, vi == 1, vi == 2);
         drain_full(vi, 1'b0, 1'b0);
      end
      tick();
      check("done_falls", 32'(bus.done), 0);

      // Stalled drain: ready high one cycle in three.
      accum_run(0, 1'b0, 1'b0);
      nxt       = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 60 && !seen_done; c++) begin
         bus.res_ready = (c % 3 == 2);
         if (bus.done) begin
            seen_done = 1'b1;
         end else if (nxt < 8) begin
            check("stall_valid", 32'(bus.res_valid), 1);
            check("stall_ch", 32'(bus.res_ch), 32'(nxt));
            check("stall_avg", 32'(bus.res_avg), 32'(vecs[0].avg[nxt]));
            if (bus.res_ready) nxt++;
         end
         tick();
      end
      bus.res_ready = 1'b0;
      check("stall_done_seen", 32'(seen_done), 1);
      check("stall_transfers", 32'(nxt), 8);

      // Strobe and start during DRAIN: overrun set, start ignored, averages intact.
      accum_run(0, 1'b0, 1'b0);
      bus.det_strobe = 1'b1;
      bus.det_data   = '1;
      bus.start      = 1'b1;
      tick();
      bus.det_strobe = 1'b0;
      bus.start      = 1'b0;
      check("ovr_set", 32'(bus.overrun), 1);
      check("ovr_still_valid", 32'(bus.res_valid), 1);
      check("ovr_ch_held", 32'(bus.res_ch), 0);
      check("ovr_busy", 32'(bus.busy), 1);
      drain_full(0, 1'b0, 1'b1);
      accum_run(1, 1'b0, 1'b0);
      drain_full(1, 1'b1, 1'b1);
      tick();

      // Reset after three results, with overrun pending.
      accum_run(1, 1'b0, 1'b0);
      bus.res_ready = 1'b1;
      repeat (3) tick();
      bus.res_ready  = 1'b0;
      bus.det_strobe = 1'b1;
      tick();
      bus.det_strobe = 1'b0;
      check("pre_reset_ch", 32'(bus.res_ch), 3);
      check("pre_reset_overrun", 32'(bus.overrun), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      tick();
      rst_n = 1'b1;
      tick();
      accum_run(0, 1'b0, 1'b0);
      drain_full(0, 1'b0, 1'b0);
      tick();
      check("final_done_low", 32'(bus.done), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/assay_readout_scanner.md
# assay_readout_scanner

Sequential readout engine on the detector end of the protein-assay chip. It consumes the eight optical detector lanes Opt1..Opt8 after the mixer stage and averages a fixed number of samples per lane. It then streams one result per lane, carrying a positive/negative threshold flag, to the host over a valid/ready interface. A run is armed by a start pulse and ends with a done pulse.

## Interface
- DW, 12: detector sample width per lane (bits).
- NSAMP, 16: samples averaged per run; power of two, 2..256.
- THRESH, 2048: averaged value at or above which a lane reports positive.

- clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle run request; honoured only in IDLE.
- busy  out  1  high in ACCUM and DRAIN.
- det_strobe  in  1  one new sample on all 8 lanes this cycle.
- det_data  in  8*DW  lane i (Opt(i+1)) at bits [i*DW +: DW], unsigned.
- res_valid  out  1  result payload valid.
- res_ready  in  1  host accepts the payload when res_valid && res_ready.
- res_ch  out  3  lane index 0..7.
- res_avg  out  DW  lane sum >> log2(NSAMP).
- res_pos  out  1  res_avg >= THRESH.
- res_last  out  1  high with res_ch == 7.
- done  out  1  one-cycle pulse after the lane-7 result is accepted.
- overrun  out  1  sticky: a strobe arrived during DRAIN; cleared by an honoured start.

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE, start=1: clear the 8 accumulators, the sample counter and overrun; go to ACCUM.
- IDLE, det_strobe: ignored; no flag.
- ACCUM, det_strobe: add each lane to its accumulator.
  - Accumulator width is DW+log2(NSAMP), so no overflow is possible.
  - The sample counter increments on each strobe.
  - On the NSAMP-th strobe, go to DRAIN with the channel pointer at 0.
- DRAIN: present lane[ptr] on the result port.
  - On handshake with ptr < 7: ptr increments.
  - On handshake with ptr == 7: go to IDLE and pulse done.
- DRAIN, det_strobe: sample discarded; overrun is set.
- start in ACCUM or DRAIN: ignored. Nothing restarts and overrun is not cleared.
- res_avg is a truncating shift with no rounding. res_pos is combinational from res_avg and THRESH.
- Reset in any state: return to IDLE and discard any partial run or pending result.

## Timing
- Reset values:
  - busy=0, res_valid=0, done=0, overrun=0.
  - res_ch=0, res_avg=0, res_pos=0 (THRESH>0), res_last=0.
  - Accumulators, counter and pointer = 0.
- start at cycle t: busy=1 at t+1. The first strobe accepted is at t+1 or later.
- NSAMP-th strobe at cycle s: res_valid=1 with res_ch=0 at s+1.
- Handshake rules:
  - Once res_valid rises, the payload and res_valid hold until the handshake.
  - There is no combinational path from res_ready to res_valid.
  - With res_ready held high, one result is transferred per cycle. Lane 7 is accepted at s+8.
- Lane-7 handshake at cycle h: res_valid=0, busy=0 and done=1 at h+1. done falls at h+2.
- A start at h+1 is honoured, giving back-to-back runs.
- Strobe and start together in IDLE: start is taken and the strobe is dropped.
- Strobe and the lane-7 handshake in the same cycle: overrun is set, because the block is still in DRAIN that cycle.

## Test plan
- NSAMP=16, THRESH=400, lane i held at 100*(i+1) for 16 strobes, res_ready=1:
  - res_avg = 100..800 on ch0..7.
  - res_pos=0 for ch0..2 and 1 for ch3..7.
  - res_last on ch7 only; done one cycle after.
- All lanes 4095 for 16 strobes: res_avg=4095 and res_pos=1 on every lane (no overflow).
- Lane 0 alternating 1,2 over 16 strobes (sum 24): res_avg=1 (truncation).
- res_ready toggles 1-of-3 cycles in DRAIN: payload is stable while stalled, and exactly 8 transfers occur in order 0..7.
- Strobes in DRAIN: overrun=1 and the averages are unchanged. The next start clears overrun.
- start pulses mid-ACCUM are ignored: the sample count still needs 16 strobes.
- rst_n low after 3 results are drained: all outputs at reset values asynchronously. A new run yields fresh averages with no carry-over.
